// File: rtl/button_conditioner.sv
// N-channel push-button front end: sync, debounce, press/release pulses, auto-repeat.
// Ports: clk, rst (async active-low), btn_in, repeat_en -> btn_level, btn_press, btn_release.
module button_conditioner #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } rep_state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   lvl_q, lvl_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    rep_state_t             st_q, st_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   acc;
    logic                   acc_press;
    logic                   acc_rel;

    assign s         = sync_q[SYNC_STAGES-1];
    assign acc       = (s != lvl_q) && (dcnt_q == D_LAST);
    assign acc_press = acc & s;
    assign acc_rel   = acc & ~s;

    always_comb begin
      dcnt_d = '0;
      lvl_d  = lvl_q;
      if (s != lvl_q) begin
        if (acc) lvl_d = s;
        else     dcnt_d = dcnt_q + D_ONE;
      end
    end

    // Release wins over everything, including a repeat
    // pulse that happens to be due on the same edge.
    always_comb begin
      st_d    = st_q;
      rcnt_d  = rcnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (acc_rel) begin
        st_d   = IDLE;
        rcnt_d = '0;
        rel_d  = 1'b1;
      end else begin
        unique case (st_q)
          IDLE: begin
            if (acc_press) begin
              press_d = 1'b1;
              if (repeat_en[i]) begin
                st_d   = DELAY;
                rcnt_d = R_ONE;
              end else begin
                st_d = HELD;
              end
            end
          end
          DELAY: begin
            if (!repeat_en[i]) begin
              st_d   = HELD;
              rcnt_d = '0;
            end else if (rcnt_q == R_DELAY) begin
              press_d = 1'b1;
              st_d    = REPEAT;
              rcnt_d  = R_ONE;
            end else begin
              rcnt_d = rcnt_q + R_ONE;
            end
          end
          REPEAT: begin
            if (!repeat_en[i]) begin
              st_d   = HELD;
              rcnt_d = '0;
            end else if (rcnt_q == R_RATE) begin
              press_d = 1'b1;
              rcnt_d  = R_ONE;
            end else begin
              rcnt_d = rcnt_q + R_ONE;
            end
          end
          HELD: begin
            st_d = HELD;
          end
          default: begin
            st_d   = IDLE;
            rcnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= '0;
        dcnt_q  <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        st_q    <= IDLE;
        rcnt_q  <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
        dcnt_q  <= dcnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        st_q    <= st_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus
// randomized stimulus against a behavioural model.
module tb_button_conditioner;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks = 0;
  int failures = 0;

  button_conditioner #(
    .N_CH(N),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYC(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: input seen SS edges late, level
  // accepted after DB consecutive differing samples, repeat
  // pulses at fixed offsets from the accepted press.
  bit       pipe [N][SS];
  bit       mlvl [N];
  int       run  [N];
  int       pt   [N];
  bit       rok  [N];
  int       t = 0;
  bit [N-1:0] exp_lvl = '0;
  bit [N-1:0] exp_pr = '0;
  bit [N-1:0] exp_rl = '0;

  always @(posedge clk or negedge rst) begin
    bit s, pr, rl;
    int d;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        for (int j = 0; j < SS; j++) pipe[c][j] = 1'b0;
        mlvl[c] = 1'b0;
        run[c]  = 0;
        rok[c]  = 1'b0;
      end
      exp_lvl = '0;
      exp_pr  = '0;
      exp_rl  = '0;
    end else begin
      t++;
      for (int c = 0; c < N; c++) begin
        s = pipe[c][SS-1];
        for (int j = SS - 1; j > 0; j--) pipe[c][j] = pipe[c][j-1];
        pipe[c][0] = btn_in[c];
        pr = 1'b0;
        rl = 1'b0;
        if (s != mlvl[c]) begin
          run[c]++;
          if (run[c] == DB) begin
            mlvl[c] = s;
            run[c]  = 0;
            if (s) begin
              pr = 1'b1;
              pt[c] = t;
              rok[c] = repeat_en[c];
            end else begin
              rl = 1'b1;
              rok[c] = 1'b0;
            end
          end
        end else begin
          run[c] = 0;
        end
        if (mlvl[c] && !pr && rok[c]) begin
          if (!repeat_en[c]) begin
            rok[c] = 1'b0;
          end else begin
            d = t - pt[c];
            if (d == RD || (d > RD && (d - RD) % RR == 0)) pr = 1'b1;
          end
        end
        exp_lvl[c] = mlvl[c];
        exp_pr[c]  = pr;
        exp_rl[c]  = rl;
      end
    end
  end

  always @(negedge clk) begin
    chk("level", btn_level, exp_lvl);
    chk("press", btn_press, exp_pr);
    chk("release", btn_release, exp_rl);
    chk("excl", |(btn_press & btn_release), 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int pq[$];
    int rq[$];
    int hold [N];
    int e3[6];
    logic bad;
    int npr, nrl;

    // 1: held buttons through reset
    btn_in = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    #1 rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) chk("s1_lvl_e5", btn_level, 2'b00);
      if (k == 6) begin
        chk("s1_lvl_e6", btn_level, 2'b11);
        chk("s1_pr_e6", btn_press, 2'b11);
      end
      if (k == 7) chk("s1_pr_e7", btn_press, 2'b00);
      #1;
    end
    btn_in = 2'b00;
    cyc(12);

    // 2: 3-cycle bounce is ignored
    bad = 1'b0;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bad |= btn_level[0] | btn_press[0];
      #1;
      btn_in[0] = (k < 3);
    end
    chk("s2_bounce", bad, 0);

    // 3: repeat timing, release collides with a due repeat
    repeat_en[0] = 1'b1;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (btn_press[0]) pq.push_back(k);
      if (btn_release[0]) rq.push_back(k);
      #1;
      btn_in[1] = 1'($urandom);
      if (k == 25) btn_in[0] = 1'b0;
    end
    e3 = '{6, 16, 19, 22, 25, 28};
    chk("s3_npress", pq.size(), 6);
    for (int j = 0; j < 6; j++)
      if (j < pq.size()) chk("s3_press_at", pq[j], e3[j]);
    chk("s3_nrel", rq.size(), 1);
    if (rq.size() > 0) chk("s3_rel_at", rq[0], 31);
    btn_in = '0;
    repeat_en = '0;
    cyc(15);

    // 4: no repeat on ch1
    npr = 0;
    nrl = 0;
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      npr += int'(btn_press[1]);
      nrl += int'(btn_release[1]);
      #1;
      if (k == 40) btn_in[1] = 1'b0;
    end
    chk("s4_npress", npr, 1);
    chk("s4_nrel", nrl, 1);

    // 5: repeat_en drop-out and re-raise
    pq.delete();
    rq.delete();
    repeat_en[0] = 1'b1;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (btn_press[0]) pq.push_back(k);
      if (btn_release[0]) rq.push_back(k);
      #1;
      if (k == 17) repeat_en[0] = 1'b0;
      if (k == 19) repeat_en[0] = 1'b1;
      if (k == 30) btn_in[0] = 1'b0;
      if (k == 37) btn_in[0] = 1'b1;
    end
    chk("s5_npress", pq.size(), 4);
    if (pq.size() == 4) begin
      chk("s5_p0", pq[0], 6);
      chk("s5_p1", pq[1], 16);
      chk("s5_p2", pq[2], 43);
      chk("s5_p3", pq[3], 53);
    end
    chk("s5_nrel", rq.size(), 1);
    if (rq.size() > 0) chk("s5_rel_at", rq[0], 36);

    // 6: reset while ch0 repeats and ch1 debounces
    btn_in[1] = 1'b1;
    cyc(2);
    rst = 1'b0;
    #1;
    chk("s6_level", btn_level, 0);
    chk("s6_press", btn_press, 0);
    chk("s6_release", btn_release, 0);
    btn_in = '0;
    cyc(2);
    rst = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bad |= |(btn_level | btn_press | btn_release);
      #1;
    end
    chk("s6_quiet", bad, 0);

    // random phase
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          hold[c] = $urandom_range(1, 40);
        end else begin
          hold[c]--;
        end
        if ($urandom_range(0, 99) < 2) repeat_en[c] = ~repeat_en[c];
      end
      if ($urandom_range(0, 999) < 2) rst = 1'b0;
    end
    rst = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
